// File: rtl/event_frame_dispatcher.sv
// Edge-detects N event channels, snapshots payload plus BCD time, arbitrates pending
// channels and streams each as a checksummed byte frame over a valid/ready handshake.
module event_frame_dispatcher #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CH_BITS   = 2,
  parameter int unsigned DATA_W    = 9,
  parameter int unsigned PAY_BYTES = 2,
  parameter int unsigned ARB_MODE  = 0,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_CH-1:0]          ev,
  input  logic [N_CH*DATA_W-1:0]   ev_data,
  input  logic [3:0]               ts_min,
  input  logic [3:0]               ts_dmin,
  input  logic [3:0]               ts_ore,
  input  logic [3:0]               ts_dore,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic [N_CH-1:0]          pend,
  output logic [7:0]               ovr_cnt,
  input  logic                     clr_ovr
);

  localparam int unsigned FRAME_LEN = 5 + PAY_BYTES;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} state_t;

  state_t                         state_q, state_d;
  logic [N_CH-1:0]                ev_q, ev_d;
  logic [N_CH-1:0]                pend_q, pend_d;
  logic [N_CH-1:0]                ovr_flag_q, ovr_flag_d;
  logic [7:0]                     ovr_cnt_q, ovr_cnt_d;
  logic [CH_BITS-1:0]             rr_ptr_q, rr_ptr_d;
  logic [CH_BITS-1:0]             grant_q, grant_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [DATA_W-1:0]              snap_data_q [N_CH];
  logic [DATA_W-1:0]              snap_data_d [N_CH];
  logic [15:0]                    snap_ts_q [N_CH];
  logic [15:0]                    snap_ts_d [N_CH];
  logic [FRAME_LEN-1:0][7:0]      frame_q, frame_d;

  logic [FRAME_LEN-1:0][7:0]      frame_new;
  logic [PAY_BYTES*8-1:0]         pay_ext;
  logic [7:0]                     chk;
  logic [N_CH-1:0]                rise;
  logic [N_CH-1:0]                clr_mask;
  logic [N_CH-1:0]                ovr_hits;
  logic [4:0]                     n_ovr;
  logic [8:0]                     cnt_sum;
  logic                           arb_hit;
  logic [CH_BITS-1:0]             arb_ch;
  logic [15:0]                    ts_now;

  assign ts_now = {ts_dore, ts_ore, ts_dmin, ts_min};

  always_comb begin
    arb_hit = 1'b0;
    arb_ch  = '0;
    if (ARB_MODE == 0) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (!arb_hit && pend_q[i]) begin
          arb_hit = 1'b1;
          arb_ch  = CH_BITS'(i);
        end
      end
    end else begin
      // search starts just after the last granted channel and wraps
      for (int unsigned j = 1; j <= N_CH; j++) begin
        int unsigned c;
        c = (32'(rr_ptr_q) + j) % N_CH;
        if (!arb_hit && pend_q[c]) begin
          arb_hit = 1'b1;
          arb_ch  = CH_BITS'(c);
        end
      end
    end
  end

  always_comb begin
    pay_ext = '0;
    pay_ext[DATA_W-1:0] = snap_data_q[grant_q];
    frame_new    = '0;
    frame_new[0] = SYNC_BYTE;
    frame_new[1] = {ovr_flag_q[grant_q], 7'(grant_q)};
    frame_new[2] = snap_ts_q[grant_q][15:8];
    frame_new[3] = snap_ts_q[grant_q][7:0];
    for (int unsigned p = 0; p < PAY_BYTES; p++) begin
      frame_new[4+p] = pay_ext[(PAY_BYTES-1-p)*8 +: 8];
    end
    chk = '0;
    for (int unsigned b = 1; b < FRAME_LEN - 1; b++) begin
      chk = chk ^ frame_new[b];
    end
    frame_new[FRAME_LEN-1] = chk;
  end

  // A rise coinciding with the grant's clear re-arms the channel without counting an overrun.
  always_comb begin
    rise     = ev & ~ev_q & {N_CH{en}};
    clr_mask = '0;
    if (state_q == ST_LOAD) begin
      clr_mask[grant_q] = 1'b1;
    end
    ovr_hits   = rise & pend_q & ~clr_mask;
    pend_d     = (pend_q & ~clr_mask) | rise;
    ovr_flag_d = (ovr_flag_q & ~clr_mask) | ovr_hits;
    ev_d       = ev;
    snap_data_d = snap_data_q;
    snap_ts_d   = snap_ts_q;
    n_ovr       = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      n_ovr = n_ovr + 5'(ovr_hits[i]);
      if (rise[i]) begin
        snap_data_d[i] = ev_data[i*DATA_W +: DATA_W];
        snap_ts_d[i]   = ts_now;
      end
    end
    cnt_sum = {1'b0, ovr_cnt_q} + 9'(n_ovr);
    if (clr_ovr) begin
      ovr_cnt_d = '0;
    end else if (cnt_sum > 9'd255) begin
      ovr_cnt_d = '1;
    end else begin
      ovr_cnt_d = cnt_sum[7:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    frame_d  = frame_q;
    tx_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_hit) begin
          grant_d = arb_ch;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        frame_d  = frame_new;
        rr_ptr_d = grant_q;
        idx_d    = '0;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_data = (state_q == ST_SEND) ? frame_q[idx_q] : '0;
  assign busy    = (state_q != ST_IDLE);
  assign pend    = pend_q;
  assign ovr_cnt = ovr_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ev_q        <= '0;
      pend_q      <= '0;
      ovr_flag_q  <= '0;
      ovr_cnt_q   <= '0;
      rr_ptr_q    <= CH_BITS'(N_CH - 1);
      grant_q     <= '0;
      idx_q       <= '0;
      frame_q     <= '0;
      snap_data_q <= '{default: '0};
      snap_ts_q   <= '{default: '0};
    end else begin
      state_q     <= state_d;
      ev_q        <= ev_d;
      pend_q      <= pend_d;
      ovr_flag_q  <= ovr_flag_d;
      ovr_cnt_q   <= ovr_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      snap_data_q <= snap_data_d;
      snap_ts_q   <= snap_ts_d;
    end
  end

endmodule
